bin2bcd_digits: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding the 4-digit

---
 rtl/digit_pkg.sv | 13 +
 rtl/bin2bcd_digits_bcd_add3.sv | 12 +
 rtl/bin2bcd_digits.sv | 116 +++++++++++
 tb/tb_bin2bcd_digits.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared digit-code definitions for the BCD converter and the 7-segment driver.
// Keeps the blank code, saturation limit and converter state encoding in one place.
package digit_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'd10;
    localparam int SAT_VALUE = 9999;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FORMAT = 2'd2;

endpackage

// File: rtl/bin2bcd_digits_bcd_add3.sv
// Shift-and-add-3 nibble correction: values 5..9 get +3 so the next left shift carries.
// Purely combinational; the caller instantiates one per BCD nibble.
module bcd_add3
    import digit_pkg::*;
(
    input  logic [DIGIT_W-1:0] n,
    output logic [DIGIT_W-1:0] q
);

    assign q = (n >= 4'd5) ? n + 4'd3 : n;

endmodule

// File: rtl/bin2bcd_digits.sv
// Sequential binary-to-BCD converter, one bit per clock, feeding the 4-digit 7-segment driver.
// Build option: LEADING_ZERO_BLANK_EN replaces leading zero digits (above units) with the blank code.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | in_ready high, waiting for in_valid
// ST_SHIFT  | WIDTH add-3/shift steps through the BCD scratch
// ST_FORMAT | register digits and ovf, pulse out_valid, back to idle
module bin2bcd_digits
    import digit_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int SAT_VALUE = digit_pkg::SAT_VALUE,
    parameter logic [3:0] BLANK_CODE = digit_pkg::BLANK_CODE
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       thousand,
    output logic [3:0]       hundred,
    output logic [3:0]       ten,
    output logic [3:0]       digit,
    output logic             out_valid,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic [3:0]       f_th;
    logic [3:0]       f_hu;
    logic [3:0]       f_te;
    logic [3:0]       f_un;

    for (genvar i = 0; i < 4; i++) begin : g_add3
        bcd_add3 u_add3 (
            .n (bcd[4*i +: 4]),
            .q (bcd_adj[4*i +: 4])
        );
    end

    assign in_ready = (state == ST_IDLE);

    // Saturated values bypass the BCD scratch, which may have wrapped for inputs above 9999.
    always_comb begin
        f_th = bcd[15:12];
        f_hu = bcd[11:8];
        f_te = bcd[7:4];
        f_un = bcd[3:0];
        if (sat) begin
            f_th = 4'd9;
            f_hu = 4'd9;
            f_te = 4'd9;
            f_un = 4'd9;
        end
`ifdef LEADING_ZERO_BLANK_EN
        else begin
            if (bcd[15:12] == 4'd0) f_th = BLANK_CODE;
            if (bcd[15:8] == 8'd0)  f_hu = BLANK_CODE;
            if (bcd[15:4] == 12'd0) f_te = BLANK_CODE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sr        <= '0;
            bcd       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            thousand  <= BLANK_CODE;
            hundred   <= BLANK_CODE;
            ten       <= BLANK_CODE;
            digit     <= BLANK_CODE;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sr    <= in_value;
                        bcd   <= '0;
                        cnt   <= '0;
                        sat   <= (32'(in_value) > SAT_VALUE);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd, sr} <= {bcd_adj, sr} << 1;
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FORMAT;
                end
                ST_FORMAT: begin
                    thousand  <= f_th;
                    hundred   <= f_hu;
                    ten       <= f_te;
                    digit     <= f_un;
                    ovf       <= sat;
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_digits.sv
// Scoreboard bench for bin2bcd_digits: directed values, expected digits queued at issue time.
module tb_bin2bcd_digits;

    localparam int WIDTH = 14;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ = 4'd10;
`else
    localparam logic [3:0] LZ = 4'd0;
`endif

    typedef struct {
        int         val;
        logic [3:0] th;
        logic [3:0] hu;
        logic [3:0] te;
        logic [3:0] un;
        logic       ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_value;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       thousand;
    logic [3:0]       hundred;
    logic [3:0]       ten;
    logic [3:0]       digit;
    logic             out_valid;
    logic             ovf;

    exp_t sb[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   total = 0;
    int   bad = 0;
    logic prev_ov = 1'b0;
    exp_t e;
    int   a;

    bin2bcd_digits #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_value  (in_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .thousand  (thousand),
        .hundred   (hundred),
        .ten       (ten),
        .digit     (digit),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int v, input logic [3:0] th, input logic [3:0] hu,
                                input logic [3:0] te, input logic [3:0] un, input logic o);
        exp_t r;
        r.val = v; r.th = th; r.hu = hu; r.te = te; r.un = un; r.ovf = o;
        return r;
    endfunction

    // Acceptance tracker: records the cycle index of every accepting edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            acc_q.push_back(cyc);
            n_acc <= n_acc + 1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_out++;
            chk("out_valid_one_cycle", int'(prev_ov), 0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected no result (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                chk($sformatf("thousand[%0d]", e.val), int'(thousand), int'(e.th));
                chk($sformatf("hundred[%0d]", e.val), int'(hundred), int'(e.hu));
                chk($sformatf("ten[%0d]", e.val), int'(ten), int'(e.te));
                chk($sformatf("digit[%0d]", e.val), int'(digit), int'(e.un));
                chk($sformatf("ovf[%0d]", e.val), int'(ovf), int'(e.ovf));
                chk($sformatf("in_ready_at_result[%0d]", e.val), int'(in_ready), 1);
                chk($sformatf("latency[%0d]", e.val), cyc - a, WIDTH + 2);
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input int v, input exp_t ex);
        int start;
        @(negedge clk);
        in_value = WIDTH'(v);
        in_valid = 1'b1;
        sb.push_back(ex);
        start = n_acc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_acc != start) break;
        end
        chk($sformatf("accepted[%0d]", v), n_acc - start, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) break;
        end
        chk("wait_idle_timeout", int'(i < 200), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int outs;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_thousand", int'(thousand), 10);
        chk("rst_hundred", int'(hundred), 10);
        chk("rst_ten", int'(ten), 10);
        chk("rst_digit", int'(digit), 10);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_ovf", int'(ovf), 0);

        send(1234, mk(1234, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0));
        wait_idle();
        send(12000, mk(12000, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1));
        wait_idle();
        repeat (5) @(negedge clk);
        chk("ovf_held", int'(ovf), 1);
        chk("digits_held", int'({thousand, hundred, ten, digit}), 16'h9999);
        send(5, mk(5, LZ, LZ, LZ, 4'd5, 1'b0));
        wait_idle();

        // Back-to-back issue: each send waits only for acceptance.
        send(0, mk(0, LZ, LZ, LZ, 4'd0, 1'b0));
        send(9999, mk(9999, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0));
        send(42, mk(42, LZ, LZ, 4'd4, 4'd2, 1'b0));
        send(305, mk(305, LZ, 4'd3, 4'd0, 4'd5, 1'b0));
        send(1000, mk(1000, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0));
        send(10000, mk(10000, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1));
        send(16383, mk(16383, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1));
        wait_idle();

        // in_valid held with a new value while busy: only taken once in_ready returns.
        @(negedge clk);
        in_value = WIDTH'(1234);
        in_valid = 1'b1;
        sb.push_back(mk(1234, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0));
        sb.push_back(mk(5678, 4'd5, 4'd6, 4'd7, 4'd8, 1'b0));
        start = n_acc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_acc != start) break;
        end
        in_value = WIDTH'(5678);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_acc - start >= 2) break;
        end
        in_valid = 1'b0;
        chk("hold_accept_count", n_acc - start, 2);
        wait_idle();

        // Reset in the middle of SHIFT abandons the conversion.
        send(9999, mk(9999, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0));
        repeat (4) @(negedge clk);
        outs = n_out;
        rst_n = 1'b0;
        #1;
        chk("midrst_thousand", int'(thousand), 10);
        chk("midrst_digit", int'(digit), 10);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        sb.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 6) @(negedge clk);
        chk("midrst_no_result", n_out - outs, 0);
        send(7, mk(7, LZ, LZ, LZ, 4'd7, 1'b0));
        wait_idle();
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
